// File: rtl/irq_request_latch_8_pkg.sv
// Shared constants and FSM state type for the eight-channel interrupt request latch.
package irq_pkg;
   localparam int NUM_CH = 8;
   localparam int IDX_W  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;
endpackage

// File: rtl/irq_request_latch_8_sync_edge.sv
// One request channel: multi-flop synchroniser, previous-value flop and event detect.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE_MODE   = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic irq_in,
   output logic evt_o
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   // Next values of the synchroniser chain and the delayed copy of its last stage
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // Synchroniser and previous-value registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{1'b0}};
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   // prev resets to 0, so a line held high through reset release yields one edge
   always_comb begin
      if (EDGE_MODE) begin
         evt_o = sync_q[SYNC_STAGES-1] & ~prev_q;
      end else begin
         evt_o = sync_q[SYNC_STAGES-1];
      end
   end
endmodule

// File: rtl/irq_request_latch_8.sv
// Interrupt capture stage: pending/overflow latches and a request handshake FSM
// presenting a frozen, masked snapshot to the downstream priority encoder.
module irq_request_latch_8
   import irq_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE_MODE   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] irq_in,
   input  logic [NUM_CH-1:0] irq_mask,
   output logic [NUM_CH-1:0] pend_out,
   output logic              en_n,
   output logic              req,
   input  logic              ack,
   input  logic [IDX_W-1:0]  ack_idx,
   output logic              ack_err,
   output logic [NUM_CH-1:0] overflow,
   input  logic              ovf_clr
);
   state_t            state_q, state_d;
   logic [NUM_CH-1:0] evt_s, masked_s, clr_s, ovf_set_s;
   logic [NUM_CH-1:0] pend_q, pend_d, ovf_q, ovf_d, pend_out_q, pend_out_d;
   logic              req_q, req_d, en_n_q, en_n_d, ack_err_q, ack_err_d;
   logic              ack_ok_s;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      irq_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES),
         .EDGE_MODE   (EDGE_MODE)
      ) u_sync (
         .clk    (clk),
         .rst_n  (rst_n),
         .irq_in (irq_in[g]),
         .evt_o  (evt_s[g])
      );
   end

   // Pending and overflow update; a new event outranks a same-cycle clear
   always_comb begin
      masked_s = pend_q & ~irq_mask;
      ack_ok_s = (state_q == REQ) && ack && pend_out_q[ack_idx];
      if (ack_ok_s) begin
         clr_s = {{(NUM_CH-1){1'b0}}, 1'b1} << ack_idx;
      end else begin
         clr_s = {NUM_CH{1'b0}};
      end
      if (EDGE_MODE) begin
         ovf_set_s = evt_s & pend_q & ~clr_s;
      end else begin
         ovf_set_s = {NUM_CH{1'b0}};
      end
      pend_d = (pend_q & ~clr_s) | evt_s;
      if (ovf_clr) begin
         ovf_d = ovf_set_s;
      end else begin
         ovf_d = ovf_q | ovf_set_s;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (|masked_s) begin
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (ack) begin
               state_d = GAP;
            end else begin
               state_d = REQ;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM output logic; the snapshot is only loaded in IDLE and frozen in REQ
   always_comb begin
      pend_out_d = pend_out_q;
      req_d      = req_q;
      en_n_d     = en_n_q;
      ack_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|masked_s) begin
               pend_out_d = masked_s;
               req_d      = 1'b1;
               en_n_d     = 1'b0;
            end else begin
               pend_out_d = {NUM_CH{1'b0}};
               req_d      = 1'b0;
               en_n_d     = 1'b1;
            end
         end
         REQ: begin
            if (ack) begin
               pend_out_d = {NUM_CH{1'b0}};
               req_d      = 1'b0;
               en_n_d     = 1'b1;
               ack_err_d  = ~pend_out_q[ack_idx];
            end else begin
               pend_out_d = pend_out_q;
            end
         end
         GAP: begin
            pend_out_d = {NUM_CH{1'b0}};
            req_d      = 1'b0;
            en_n_d     = 1'b1;
         end
         default: begin
            pend_out_d = {NUM_CH{1'b0}};
            req_d      = 1'b0;
            en_n_d     = 1'b1;
         end
      endcase
   end

   // Pending, overflow and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q     <= {NUM_CH{1'b0}};
         ovf_q      <= {NUM_CH{1'b0}};
         pend_out_q <= {NUM_CH{1'b0}};
         req_q      <= 1'b0;
         en_n_q     <= 1'b1;
         ack_err_q  <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         ovf_q      <= ovf_d;
         pend_out_q <= pend_out_d;
         req_q      <= req_d;
         en_n_q     <= en_n_d;
         ack_err_q  <= ack_err_d;
      end
   end

   assign pend_out = pend_out_q;
   assign req      = req_q;
   assign en_n     = en_n_q;
   assign ack_err  = ack_err_q;
   assign overflow = ovf_q;
endmodule
